// File: rtl/i2c_slave_target.sv
// I2C target (slave) with a byte-wide user interface: write bytes are delivered on
// rx_data/rx_valid, read bytes are fetched through the tx_load/tx_data handshake.

module i2c_glitch_filter #(
    parameter int FILT = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pad_i,
    output logic filt_o
);
    localparam int CW = (FILT < 2) ? 1 : $clog2(FILT + 1);

    logic [1:0]    sync_q, sync_d;
    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The filtered level only follows the synchronised level after it has
    // differed from it for FILT consecutive cycles.
    always_comb begin
        sync_d = {sync_q[0], pad_i};
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync_q[1] != filt_q) begin
            if (cnt_q == CW'(FILT - 1)) begin
                filt_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: reset to 1 so an idle bus is not mistaken for a START/STOP edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= 2'b11;
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filt_o = filt_q;
endmodule

module i2c_slave_target #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         FILT       = 3
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       scl_pad_i,
    input  logic       sda_pad_i,
    output logic       scl_pad_o,
    output logic       scl_padoen_o,
    output logic       sda_pad_o,
    output logic       sda_padoen_o,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic       addressed,
    output logic       stop_det
);
    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_ACK,
        WAIT_STOP
    } state_e;

    logic scl_f, sda_f;
    logic scl_prev_q, sda_prev_q;
    logic scl_rise, scl_fall, start_seen, stop_seen;

    state_e     state_q;
    logic [2:0] bit_cnt_q;
    logic [6:0] shift_q;
    logic [6:0] tx_shift_q;
    logic       rw_q;
    logic       phase_q;
    logic       sda_oen_q;
    logic       addressed_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       tx_load_q;
    logic       stop_det_q;

    i2c_glitch_filter #(.FILT(FILT)) u_scl_filt (
        .clk_i  (wb_clk_i),
        .rst_i  (wb_rst_i),
        .pad_i  (scl_pad_i),
        .filt_o (scl_f)
    );

    i2c_glitch_filter #(.FILT(FILT)) u_sda_filt (
        .clk_i  (wb_clk_i),
        .rst_i  (wb_rst_i),
        .pad_i  (sda_pad_i),
        .filt_o (sda_f)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_f;
            sda_prev_q <= sda_f;
        end
    end

    assign scl_rise   = scl_f & ~scl_prev_q;
    assign scl_fall   = ~scl_f & scl_prev_q;
    assign start_seen = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
    assign stop_seen  = scl_f & scl_prev_q & ~sda_prev_q & sda_f;

    // NOTE: all protocol state is sequential, so every assignment here is non-blocking.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tx_shift_q  <= '0;
            rw_q        <= 1'b0;
            phase_q     <= 1'b0;
            sda_oen_q   <= 1'b1;
            addressed_q <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_load_q   <= 1'b0;
            stop_det_q  <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            tx_load_q  <= 1'b0;
            stop_det_q <= 1'b0;

            if (stop_seen) begin
                state_q     <= IDLE;
                sda_oen_q   <= 1'b1;
                addressed_q <= 1'b0;
                stop_det_q  <= 1'b1;
            end else if (start_seen) begin
                state_q     <= ADDR;
                bit_cnt_q   <= '0;
                sda_oen_q   <= 1'b1;
                addressed_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE, WAIT_STOP: begin
                        sda_oen_q <= 1'b1;
                    end

                    ADDR: begin
                        if (scl_rise) begin
                            shift_q   <= {shift_q[5:0], sda_f};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                rw_q    <= sda_f;
                                phase_q <= 1'b0;
                                state_q <= (shift_q == SLAVE_ADDR) ? ADDR_ACK : WAIT_STOP;
                            end
                        end
                    end

                    // phase_q=0: waiting for the falling edge that opens the ACK slot;
                    // phase_q=1: ACK is on the bus until the falling edge that closes it.
                    ADDR_ACK, WR_ACK: begin
                        if (scl_fall) begin
                            if (!phase_q) begin
                                sda_oen_q <= 1'b0;
                                phase_q   <= 1'b1;
                                if (state_q == ADDR_ACK) begin
                                    addressed_q <= 1'b1;
                                end
                            end else begin
                                bit_cnt_q <= '0;
                                if (state_q == ADDR_ACK && rw_q) begin
                                    state_q   <= RD_BYTE;
                                    tx_load_q <= 1'b1;
                                end else begin
                                    state_q   <= WR_BYTE;
                                    sda_oen_q <= 1'b1;
                                end
                            end
                        end
                    end

                    WR_BYTE: begin
                        if (scl_rise) begin
                            shift_q   <= {shift_q[5:0], sda_f};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                if (rx_ready) begin
                                    rx_data_q  <= {shift_q, sda_f};
                                    rx_valid_q <= 1'b1;
                                    phase_q    <= 1'b0;
                                    state_q    <= WR_ACK;
                                end else begin
                                    state_q <= WAIT_STOP;
                                end
                            end
                        end
                    end

                    // tx_data is captured at the end of the tx_load cycle so the user
                    // may answer the request combinationally; SCL is still low then.
                    RD_BYTE: begin
                        if (tx_load_q) begin
                            sda_oen_q  <= tx_data[7];
                            tx_shift_q <= tx_data[6:0];
                        end else if (scl_fall) begin
                            if (bit_cnt_q == 3'd7) begin
                                sda_oen_q <= 1'b1;
                                phase_q   <= 1'b0;
                                state_q   <= RD_ACK;
                            end else begin
                                sda_oen_q  <= tx_shift_q[6];
                                tx_shift_q <= {tx_shift_q[5:0], 1'b1};
                                bit_cnt_q  <= bit_cnt_q + 3'd1;
                            end
                        end
                    end

                    RD_ACK: begin
                        if (scl_rise) begin
                            if (sda_f) begin
                                state_q <= WAIT_STOP;
                            end else begin
                                phase_q <= 1'b1;
                            end
                        end else if (scl_fall && phase_q) begin
                            state_q   <= RD_BYTE;
                            tx_load_q <= 1'b1;
                            bit_cnt_q <= '0;
                        end
                    end

                    default: begin
                        state_q   <= IDLE;
                        sda_oen_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign scl_pad_o    = 1'b0;
    assign scl_padoen_o = 1'b1;
    assign sda_pad_o    = 1'b0;
    assign sda_padoen_o = sda_oen_q;
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign tx_load      = tx_load_q;
    assign addressed    = addressed_q;
    assign stop_det     = stop_det_q;
endmodule

// File: tb/tb_i2c_slave_target.sv
// Directed bench for i2c_slave_target: an I2C master model on a wired-AND bus
// with hand-computed ACK bits, read data and pulse counts.

module tb_i2c_slave_target;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] tx_data = 8'h00;

    logic       scl_pad_o, scl_padoen_o, sda_pad_o, sda_padoen_o;
    logic [7:0] rx_data;
    logic       rx_valid, tx_load, addressed, stop_det;
    logic       sda_line, scl_line;

    int checks = 0;
    int errors = 0;
    int rxv_cnt = 0, txl_cnt = 0, stop_cnt = 0, drv_cnt = 0;

    assign sda_line = sda_m & (sda_padoen_o | sda_pad_o);
    assign scl_line = scl_m & (scl_padoen_o | scl_pad_o);

    i2c_slave_target #(.SLAVE_ADDR(7'h50), .FILT(3)) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .scl_pad_i    (scl_line),
        .sda_pad_i    (sda_line),
        .scl_pad_o    (scl_pad_o),
        .scl_padoen_o (scl_padoen_o),
        .sda_pad_o    (sda_pad_o),
        .sda_padoen_o (sda_padoen_o),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .tx_data      (tx_data),
        .tx_load      (tx_load),
        .addressed    (addressed),
        .stop_det     (stop_det)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rx_valid)      rxv_cnt  <= rxv_cnt + 1;
        if (tx_load)       txl_cnt  <= txl_cnt + 1;
        if (stop_det)      stop_cnt <= stop_cnt + 1;
        if (!sda_padoen_o) drv_cnt  <= drv_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // SCL low 20 cycles, high 20 cycles; SDA moves 5 cycles into the low phase.
    task automatic send_bit(input logic b, output logic line);
        wait_cyc(5);
        sda_m = b;
        wait_cyc(15);
        scl_m = 1'b1;
        wait_cyc(10);
        line = sda_line;
        wait_cyc(10);
        scl_m = 1'b0;
    endtask

    task automatic send_start();
        if (!scl_m) begin
            wait_cyc(5);
            sda_m = 1'b1;
            wait_cyc(15);
            scl_m = 1'b1;
        end
        wait_cyc(10);
        sda_m = 1'b0;
        wait_cyc(10);
        scl_m = 1'b0;
    endtask

    task automatic send_stop();
        wait_cyc(5);
        sda_m = 1'b0;
        wait_cyc(15);
        scl_m = 1'b1;
        wait_cyc(10);
        sda_m = 1'b1;
        wait_cyc(20);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic dummy;
        for (int i = 7; i >= 0; i--) send_bit(b[i], dummy);
        send_bit(1'b1, ack);
    endtask

    task automatic read_byte(output logic [7:0] d);
        for (int i = 7; i >= 0; i--) send_bit(1'b1, d[i]);
    endtask

    initial begin
        logic       ack, dummy;
        logic [7:0] d;
        int         rxv0, txl0, stop0, drv0;

        // Reset state
        wait_cyc(5);
        rst = 1'b0;
        wait_cyc(2);
        check("rst_sda_oen", sda_padoen_o, 1);
        check("rst_addressed", addressed, 0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_tx_load", tx_load, 0);
        check("rst_stop_det", stop_det, 0);
        check("rst_scl_oen", scl_padoen_o, 1);
        check("rst_scl_o", scl_pad_o, 0);
        check("rst_sda_o", sda_pad_o, 0);

        // Write A0 / 3C
        rxv0 = rxv_cnt; stop0 = stop_cnt;
        send_start();
        write_byte(8'hA0, ack);
        check("wr_addr_ack", ack, 0);
        check("wr_addressed", addressed, 1);
        write_byte(8'h3C, ack);
        check("wr_data_ack", ack, 0);
        send_stop();
        check("wr_rx_data", rx_data, 8'h3C);
        check("wr_rx_valid_cnt", rxv_cnt - rxv0, 1);
        check("wr_stop_cnt", stop_cnt - stop0, 1);
        check("wr_addr_clear", addressed, 0);

        // Address mismatch
        rxv0 = rxv_cnt; drv0 = drv_cnt;
        send_start();
        write_byte(8'hA2, ack);
        check("mm_addr_nack", ack, 1);
        write_byte(8'h5A, ack);
        check("mm_data_nack", ack, 1);
        check("mm_addressed", addressed, 0);
        send_stop();
        check("mm_never_drv", drv_cnt - drv0, 0);
        check("mm_rx_valid_cnt", rxv_cnt - rxv0, 0);

        // Read 96 then 5A
        tx_data = 8'h96;
        txl0 = txl_cnt; stop0 = stop_cnt;
        send_start();
        write_byte(8'hA1, ack);
        check("rd_addr_ack", ack, 0);
        read_byte(d);
        check("rd_byte0", d, 8'h96);
        tx_data = 8'h5A;
        send_bit(1'b0, dummy);
        read_byte(d);
        check("rd_byte1", d, 8'h5A);
        send_bit(1'b1, dummy);
        wait_cyc(10);
        check("rd_release", sda_padoen_o, 1);
        check("rd_tx_load_cnt", txl_cnt - txl0, 2);
        check("rd_addressed", addressed, 1);
        send_stop();
        check("rd_stop_cnt", stop_cnt - stop0, 1);

        // rx_ready low -> NACK, later bytes ignored
        rxv0 = rxv_cnt;
        send_start();
        write_byte(8'hA0, ack);
        check("nr_addr_ack", ack, 0);
        rx_ready = 1'b0;
        write_byte(8'h77, ack);
        check("nr_data_nack", ack, 1);
        rx_ready = 1'b1;
        write_byte(8'h11, ack);
        check("nr_ignored_nack", ack, 1);
        check("nr_rx_data", rx_data, 8'h3C);
        check("nr_rx_valid_cnt", rxv_cnt - rxv0, 0);
        send_stop();

        // Repeated START mid-byte
        send_start();
        write_byte(8'hA0, ack);
        check("rs_addr_ack0", ack, 0);
        send_bit(1'b1, dummy);
        send_bit(1'b0, dummy);
        send_bit(1'b1, dummy);
        send_bit(1'b0, dummy);
        send_start();
        check("rs_release", sda_padoen_o, 1);
        check("rs_addr_clear", addressed, 0);
        write_byte(8'hA0, ack);
        check("rs_addr_ack1", ack, 0);
        check("rs_addressed", addressed, 1);
        write_byte(8'h55, ack);
        check("rs_data_ack", ack, 0);
        send_stop();
        check("rs_rx_data", rx_data, 8'h55);

        // Reset while driving a read bit
        tx_data = 8'h00;
        stop0 = stop_cnt;
        send_start();
        write_byte(8'hA1, ack);
        check("mr_addr_ack", ack, 0);
        wait_cyc(20);
        scl_m = 1'b1;
        wait_cyc(5);
        check("mr_pre_drv", sda_padoen_o, 0);
        rst = 1'b1;
        wait_cyc(1);
        check("mr_sda_oen", sda_padoen_o, 1);
        check("mr_addressed", addressed, 0);
        check("mr_rx_valid", rx_valid, 0);
        rst = 1'b0;
        wait_cyc(14);
        scl_m = 1'b0;
        drv0 = drv_cnt;
        for (int i = 0; i < 3; i++) send_bit(1'b1, dummy);
        check("mr_ignored_drv", drv_cnt - drv0, 0);
        check("mr_still_idle", addressed, 0);
        send_stop();
        check("mr_stop_cnt", stop_cnt - stop0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_slave_target.md
I2C_SLAVE_TARGET -- requirements
Module: i2c_slave_target

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'h50, 7-bit bus address to which the block responds.
REQ-002 Parameter FILT, default 3, number of consecutive wb_clk_i cycles a synchronised pad level must hold before it is accepted.
REQ-003 The block SHALL use one clock, wb_clk_i; reset wb_rst_i SHALL be synchronous and active-high.
REQ-004 wb_clk_i  in  1  system clock.
REQ-005 wb_rst_i  in  1  synchronous active-high reset.
REQ-006 scl_pad_i  in  1  SCL line level.
REQ-007 sda_pad_i  in  1  SDA line level.
REQ-008 scl_pad_o / scl_padoen_o  out  1/1  tied 0/1; the block never stretches SCL.
REQ-009 sda_pad_o  out  1  tied 0.
REQ-010 sda_padoen_o  out  1  SDA output enable, active-low; 0 pulls SDA low.
REQ-011 rx_data  out  8  last accepted write byte.
REQ-012 rx_valid  out  1  one-cycle pulse when rx_data is updated.
REQ-013 rx_ready  in  1  user can accept a byte; sampled at the 8th data bit.
REQ-014 tx_data  in  8  read byte; sampled in the cycle tx_load is high.
REQ-015 tx_load  out  1  one-cycle pulse requesting and capturing tx_data.
REQ-016 addressed  out  1  high from address ACK until the next START or STOP.
REQ-017 stop_det  out  1  one-cycle pulse on every detected STOP.

Function
REQ-018 SCL and SDA SHALL each pass through a 2-flop synchroniser and then a FILT-cycle stability filter, producing scl_f and sda_f; pad-to-filtered latency is 2+FILT cycles.
REQ-019 START = sda_f falling while scl_f is high; STOP = sda_f rising while scl_f is high; both SHALL be detected in every state.
REQ-020 Data SHALL be sampled on the scl_f rising edge, MSB first; SDA drive SHALL change only on the scl_f falling edge (the cycle the edge is detected).
REQ-021 States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
REQ-022 START from any state -> ADDR with bit count 0, sda_padoen_o=1, addressed=0.
REQ-023 STOP from any state -> IDLE, sda_padoen_o=1, addressed=0, stop_det pulse.
REQ-024 ADDR: shift 8 bits; on the 8th rising edge compare bits[7:1] with SLAVE_ADDR. Match -> ADDR_ACK; mismatch -> WAIT_STOP with SDA never driven.
REQ-025 ADDR_ACK: drive sda_padoen_o=0 from the next falling edge to the following falling edge; set addressed=1. Then go to WR_BYTE if R/W=0, or to RD_BYTE if R/W=1.
REQ-026 WR_BYTE: shift 8 bits. On the 8th rising edge, if rx_ready=1, load rx_data and pulse rx_valid, then ACK in WR_ACK. If rx_ready=0, do not update rx_data, raise no rx_valid, release SDA for bit 9 (NACK), and go to WAIT_STOP.
REQ-027 WR_ACK: SDA low for exactly one SCL period, as in REQ-025, then WR_BYTE.
REQ-028 RD_BYTE: at the falling edge that ends the previous ACK phase, pulse tx_load, capture tx_data, and drive bit 7 immediately (sda_padoen_o = data bit, so a 1 releases SDA). Shift on each following falling edge.
REQ-029 After the 8th bit, SDA SHALL be released at the next falling edge.
REQ-030 RD_ACK: sample master SDA on the 9th rising edge. 0 (ACK) -> reload per REQ-028 at the next falling edge. 1 (NACK) -> WAIT_STOP with SDA released.
REQ-031 WAIT_STOP: SDA released; leave only on START or STOP.
REQ-032 A START or STOP detected while the block is driving SDA SHALL release SDA in the same cycle as the detection.
REQ-033 Correct operation requires SCL high and SCL low each to last ≥ FILT+4 wb_clk_i cycles; shorter pulses may be filtered out.

Reset
REQ-034 On wb_rst_i=1 at a clock edge: state=IDLE, sda_padoen_o=1, rx_data=8'h00, rx_valid=0, tx_load=0, addressed=0, stop_det=0, and synchroniser/filter registers = 1 (bus idle).
REQ-035 Reset asserted mid-transfer SHALL release SDA at that edge and ignore bus activity until a fresh START.

Verification
REQ-036 Hold wb_rst_i=1 with SDA being driven in a read -> next edge: sda_padoen_o=1, addressed=0, rx_valid=0.
REQ-037 START, byte 8'hA0, byte 8'h3C, STOP, with rx_ready=1 -> SDA low on both 9th clocks, rx_data=8'h3C with one rx_valid pulse, one stop_det pulse.
REQ-038 START, byte 8'hA2 (address mismatch), one data byte, STOP -> sda_padoen_o=1 throughout, addressed=0, no rx_valid.
REQ-039 START, byte 8'hA1, tx_data=8'h96, master ACK, tx_data=8'h5A, master NACK -> SDA bits 1,0,0,1,0,1,1,0 then 0,1,0,1,1,0,1,0; two tx_load pulses; SDA released after the NACK.
REQ-040 Write with rx_ready=0 at the 8th bit -> SDA released on the 9th clock (NACK), rx_data unchanged, no rx_valid, block ignores further bytes until START or STOP.
REQ-041 Repeated START after the 4th bit of a data byte, followed by 8'hA0 -> SDA released, re-addressed, and ACKs again.
